// File: rtl/keypad_entry.sv
// Keypad digit-entry controller: debounced-by-edge key capture, BCD entry register,
// ASCII key echo strobe and multiplexed 7-segment display scan.
module keypad_entry #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             i_sw_push,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_seg_com,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [3:0]              o_count,
  output logic                    o_full,
  output logic [7:0]              o_lcd_data,
  output logic                    o_lcd_valid
);

  // state | meaning
  // IDLE  | no key down; next nonzero sample may be accepted
  // HELD  | key(s) down; waiting for all-zero sample before another event

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]    FULL_CNT  = 4'(NUM_DIGITS);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {IDLE, HELD} state_t;

  state_t state, state_nxt;
  logic [11:0] sample;
  logic        accept;
  logic        one_hot;
  logic        is_digit, is_clear, is_bs;
  logic [3:0]  digit;

  logic [4*NUM_DIGITS-1:0] value_nxt;
  logic [3:0]              count_nxt;
  logic [7:0]              lcd_data_nxt;
  logic                    lcd_valid_nxt;

  logic [CW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [3:0]    cur_bcd;
  logic          cur_show;
  logic [7:0]    seg_nxt;

  function automatic logic [7:0] seg_code(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = 8'hFC;
      4'd1:    code = 8'h60;
      4'd2:    code = 8'hDA;
      4'd3:    code = 8'hF2;
      4'd4:    code = 8'h66;
      4'd5:    code = 8'hB6;
      4'd6:    code = 8'hBE;
      4'd7:    code = 8'hE0;
      4'd8:    code = 8'hFE;
      4'd9:    code = 8'hF6;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  assign one_hot = (sample != 12'h000) && ((sample & (sample - 12'h001)) == 12'h000);
  assign is_clear = sample[1];
  assign is_bs    = sample[0];
  assign o_full   = (o_count == FULL_CNT);

  // Digit d lives on bit 11-d; only meaningful when the sample is one-hot.
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (sample[11-i]) begin
        is_digit = 1'b1;
        digit    = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sample <= 12'h000;
    end else begin
      state  <= state_nxt;
      sample <= i_sw_push;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (sample != 12'h000) begin
          state_nxt = HELD;
          accept    = one_hot;
        end
      end
      HELD: begin
        if (sample == 12'h000) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    value_nxt     = o_value;
    count_nxt     = o_count;
    lcd_data_nxt  = o_lcd_data;
    lcd_valid_nxt = 1'b0;
    if (accept) begin
      if (is_clear) begin
        value_nxt     = '0;
        count_nxt     = 4'd0;
        lcd_data_nxt  = 8'h20;
        lcd_valid_nxt = 1'b1;
      end else if (is_bs) begin
        if (o_count != 4'd0) begin
          value_nxt     = o_value >> 4;
          count_nxt     = o_count - 4'd1;
          lcd_data_nxt  = 8'h08;
          lcd_valid_nxt = 1'b1;
        end
      end else if (is_digit && !o_full) begin
        value_nxt       = o_value << 4;
        value_nxt[3:0]  = digit;
        count_nxt       = o_count + 4'd1;
        lcd_data_nxt    = 8'h30 + {4'h0, digit};
        lcd_valid_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_value     <= '0;
      o_count     <= 4'd0;
      o_lcd_data  <= 8'h20;
      o_lcd_valid <= 1'b0;
    end else begin
      o_value     <= value_nxt;
      o_count     <= count_nxt;
      o_lcd_data  <= lcd_data_nxt;
      o_lcd_valid <= lcd_valid_nxt;
    end
  end

  // Display scan runs independently of key handling, so both can act in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    o_seg_com      = '1;
    o_seg_com[idx] = 1'b0;
  end

  always_comb begin
    cur_bcd  = 4'd0;
    cur_show = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_bcd  = o_value[4*i +: 4];
        cur_show = (4'(i) < o_count);
      end
    end
    seg_nxt = cur_show ? seg_code(cur_bcd) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_seg <= 8'h00;
    else      o_seg <= seg_nxt;
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed self-checking bench for keypad_entry with a 4-slot display scanned every 4 clocks.
module tb_keypad_entry;

  localparam int ND = 4;
  localparam logic [11:0] K_CLR = 12'h002;
  localparam logic [11:0] K_BS  = 12'h001;

  logic          clk;
  logic          rst;
  logic [11:0]   i_sw_push;
  logic [7:0]    o_seg;
  logic [ND-1:0] o_seg_com;
  logic [4*ND-1:0] o_value;
  logic [3:0]    o_count;
  logic          o_full;
  logic [7:0]    o_lcd_data;
  logic          o_lcd_valid;

  int checks = 0;
  int failures = 0;
  logic [7:0] sq[$];

  localparam logic [41:0] RESET_VEC = {16'h0000, 4'd0, 1'b0, 8'h20, 1'b0, 8'h00, 4'b1110};

  keypad_entry #(.NUM_DIGITS(ND), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .i_sw_push(i_sw_push), .o_seg(o_seg), .o_seg_com(o_seg_com),
    .o_value(o_value), .o_count(o_count), .o_full(o_full),
    .o_lcd_data(o_lcd_data), .o_lcd_valid(o_lcd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_lcd_valid === 1'b1) sq.push_back(o_lcd_data);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] kd(input int d);
    logic [11:0] top;
    top = 12'h800;
    return top >> d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [11:0] p, input int hold);
    i_sw_push = p;
    tick(hold);
    i_sw_push = 12'h000;
    tick(3);
  endtask

  task automatic clear_all();
    press(K_CLR, 2);
    sq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_sw_push = 12'h000;
    tick(2);
    checks++;
    if ({o_value, o_count, o_full, o_lcd_data, o_lcd_valid, o_seg, o_seg_com} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h",
               {o_value, o_count, o_full, o_lcd_data, o_lcd_valid, o_seg, o_seg_com}, RESET_VEC);
    end
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_latency();
    i_sw_push = kd(7);
    tick(1);
    checks++;
    if (o_count !== 4'd0 || o_lcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: count=%0d valid=%b expected 0/0", o_count, o_lcd_valid);
    end
    tick(1);
    checks++;
    if (o_value !== 16'h0007 || o_count !== 4'd1 || o_lcd_valid !== 1'b1 || o_lcd_data !== 8'h37) begin
      failures++;
      $display("FAIL latency_second_edge: value=%h count=%0d valid=%b data=%h expected 0007/1/1/37",
               o_value, o_count, o_lcd_valid, o_lcd_data);
    end
    tick(1);
    checks++;
    if (o_lcd_valid !== 1'b0 || o_lcd_data !== 8'h37) begin
      failures++;
      $display("FAIL strobe_width: valid=%b data=%h expected 0/37", o_lcd_valid, o_lcd_data);
    end
    tick(10);
    checks++;
    if (o_count !== 4'd1) begin
      failures++;
      $display("FAIL no_repeat: count=%0d expected 1", o_count);
    end
    i_sw_push = 12'h000;
    tick(3);
  endtask

  task automatic test_digits();
    clear_all();
    press(kd(1), 2);
    press(kd(2), 2);
    press(kd(3), 2);
    checks++;
    if (o_value !== 16'h0123 || o_count !== 4'd3) begin
      failures++;
      $display("FAIL digits_value: value=%h count=%0d expected 0123/3", o_value, o_count);
    end
    checks++;
    if (sq.size() != 3 || {sq[0], sq[1], sq[2]} !== 24'h313233) begin
      failures++;
      $display("FAIL digits_strobes: n=%0d first=%h expected 3 strobes 31,32,33", sq.size(),
               (sq.size() > 0) ? sq[0] : 8'hxx);
    end
  endtask

  task automatic test_full();
    int n0;
    clear_all();
    press(kd(5), 2);
    press(kd(6), 2);
    press(kd(7), 2);
    press(kd(8), 2);
    checks++;
    if (o_value !== 16'h5678 || o_count !== 4'd4 || o_full !== 1'b1 || sq.size() != 4) begin
      failures++;
      $display("FAIL full_fill: value=%h count=%0d full=%b strobes=%0d expected 5678/4/1/4",
               o_value, o_count, o_full, sq.size());
    end
    n0 = sq.size();
    press(kd(9), 2);
    checks++;
    if (o_value !== 16'h5678 || o_count !== 4'd4 || sq.size() != n0) begin
      failures++;
      $display("FAIL full_ignore: value=%h count=%0d strobes=%0d expected 5678/4/%0d",
               o_value, o_count, sq.size(), n0);
    end
    press(K_BS, 2);
    checks++;
    if (o_value !== 16'h0567 || o_count !== 4'd3 || o_full !== 1'b0 || o_lcd_data !== 8'h08 ||
        sq.size() != n0 + 1) begin
      failures++;
      $display("FAIL backspace: value=%h count=%0d full=%b data=%h strobes=%0d expected 0567/3/0/08/%0d",
               o_value, o_count, o_full, o_lcd_data, sq.size(), n0 + 1);
    end
  endtask

  task automatic test_hold_multi();
    clear_all();
    i_sw_push = kd(4);
    tick(50);
    i_sw_push = 12'h090;
    tick(5);
    i_sw_push = 12'h000;
    tick(3);
    press(12'h090, 3);
    checks++;
    if (sq.size() != 1 || o_value !== 16'h0004 || o_count !== 4'd1) begin
      failures++;
      $display("FAIL hold_multi: strobes=%0d value=%h count=%0d expected 1/0004/1",
               sq.size(), o_value, o_count);
    end
    checks++;
    if (sq.size() != 1 || sq[0] !== 8'h34) begin
      failures++;
      $display("FAIL hold_multi_data: strobes=%0d expected single 34", sq.size());
    end
  endtask

  task automatic scan_check(input logic [31:0] exp_seg, input string tag);
    int n;
    logic [7:0] e;
    logic [3:0] ecom;
    logic [3:0] one;
    n = 0;
    while (o_seg_com !== 4'b0111 && n < 100) begin tick(1); n++; end
    while (o_seg_com !== 4'b1110 && n < 100) begin tick(1); n++; end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL %s_sync: o_seg_com=%b never reached slot 0", tag, o_seg_com);
    end
    tick(1);
    one = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      e = exp_seg[8*k +: 8];
      ecom = ~(one << k);
      checks++;
      if (o_seg !== e || o_seg_com !== ecom) begin
        failures++;
        $display("FAIL %s_pos%0d: seg=%h com=%b expected %h/%b", tag, k, o_seg, o_seg_com, e, ecom);
      end
      tick(4);
    end
  endtask

  task automatic test_scan();
    clear_all();
    press(kd(4), 2);
    press(kd(2), 2);
    checks++;
    if (o_value !== 16'h0042 || o_count !== 4'd2) begin
      failures++;
      $display("FAIL scan_setup: value=%h count=%0d expected 0042/2", o_value, o_count);
    end
    scan_check({8'h00, 8'h00, 8'h66, 8'hDA}, "scan42");
    clear_all();
    press(kd(4), 2);
    press(kd(5), 2);
    scan_check({8'h00, 8'h00, 8'h66, 8'hB6}, "scan45");
  endtask

  task automatic test_clear_bs_empty();
    clear_all();
    press(K_CLR, 2);
    press(K_BS, 2);
    checks++;
    if (sq.size() != 1 || o_value !== 16'h0000 || o_count !== 4'd0 || o_lcd_data !== 8'h20) begin
      failures++;
      $display("FAIL clear_bs_empty: strobes=%0d value=%h count=%0d data=%h expected 1/0000/0/20",
               sq.size(), o_value, o_count, o_lcd_data);
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    i_sw_push = kd(1);
    tick(1);
    i_sw_push = 12'h000;
    tick(1);
    i_sw_push = kd(2);
    tick(1);
    i_sw_push = 12'h000;
    tick(4);
    checks++;
    if (o_value !== 16'h0012 || o_count !== 4'd2 || sq.size() != 2) begin
      failures++;
      $display("FAIL back_to_back: value=%h count=%0d strobes=%0d expected 0012/2/2",
               o_value, o_count, sq.size());
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_all();
    press(kd(1), 2);
    press(kd(2), 2);
    i_sw_push = kd(3);
    tick(1);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({o_value, o_count, o_full, o_lcd_data, o_lcd_valid, o_seg, o_seg_com} !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_mid: got %h expected %h",
               {o_value, o_count, o_full, o_lcd_data, o_lcd_valid, o_seg, o_seg_com}, RESET_VEC);
    end
    i_sw_push = 12'h000;
    n0 = sq.size();
    tick(3);
    rst = 1'b1;
    tick(6);
    checks++;
    if (sq.size() != n0 || o_count !== 4'd0 || o_value !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_after: strobes=%0d count=%0d value=%h expected %0d/0/0000",
               sq.size(), o_count, o_value, n0);
    end
  endtask

  task automatic test_held_through_reset();
    rst = 1'b0;
    i_sw_push = kd(6);
    tick(2);
    sq.delete();
    rst = 1'b1;
    tick(4);
    checks++;
    if (o_value !== 16'h0006 || o_count !== 4'd1 || sq.size() != 1 || o_lcd_data !== 8'h36) begin
      failures++;
      $display("FAIL held_through_reset: value=%h count=%0d strobes=%0d data=%h expected 0006/1/1/36",
               o_value, o_count, sq.size(), o_lcd_data);
    end
    tick(10);
    checks++;
    if (sq.size() != 1) begin
      failures++;
      $display("FAIL held_no_repeat: strobes=%0d expected 1", sq.size());
    end
    i_sw_push = 12'h000;
    tick(3);
  endtask

  initial begin
    rst = 1'b0;
    i_sw_push = 12'h000;
    test_reset();
    test_latency();
    test_digits();
    test_full();
    test_hold_multi();
    test_scan();
    test_clear_bs_empty();
    test_back_to_back();
    test_reset_mid();
    test_held_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
